// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Holds the ALU mode encoding, sequencer states and a mode legality helper.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        SLL = 4'd5,
        SRL = 4'd6,
        MUL = 4'd7
    } alu_mode;

    localparam logic [3:0] ALU_MODE_MAX = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    function automatic logic mode_is_legal(input logic [3:0] m);
        return (m <= ALU_MODE_MAX);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU evaluating one alu_mode operation on two operands.
// Ports: a, b (WIDTH) operands; mode (4) operation; result (WIDTH),
// carry (carry/borrow for ADD/SUB), err (mode outside alu_mode).
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0] sum;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        err    = 1'b0;
        sum    = '0;
        if (!mode_is_legal(mode)) begin
            err = 1'b1;
        end else begin
            case (alu_mode'(mode))
                ADD: begin
                    sum    = {1'b0, a} + {1'b0, b};
                    result = sum[WIDTH-1:0];
                    carry  = sum[WIDTH];
                end
                SUB: begin
                    // bit WIDTH of the extended difference is the borrow
                    sum    = {1'b0, a} - {1'b0, b};
                    result = sum[WIDTH-1:0];
                    carry  = sum[WIDTH];
                end
                AND: result = a & b;
                OR:  result = a | b;
                XOR: result = a ^ b;
                SLL: result = a << b[SHW-1:0];
                SRL: result = a >> b[SHW-1:0];
                MUL: result = a * b;
                default: err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: queues ALU commands in a FIFO, executes them in order
// and returns one response per command over a valid/ready handshake.
// Ports: clk, rst (sync, active-high); cmd_* command input channel;
// rsp_* response output channel; fifo_count current queue occupancy.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [3:0]               cmd_mode,
    input  logic [3:0]               cmd_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_carry,
    output logic [3:0]               rsp_tag,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       mode;
        logic [3:0]       tag;
    } cmd_t;

    seq_state_e state_q, state_d;

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    cmd_t op_q, op_d;

    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [3:0]       rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_err;

    logic push;
    logic pop;
    logic fifo_empty;

    // Ready uses only registered occupancy; rst gates it so nothing is
    // accepted during reset.
    assign cmd_ready  = !rst && (count_q < CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count_q == '0);

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (op_q.a),
        .b      (op_q.b),
        .mode   (op_q.mode),
        .result (alu_result),
        .carry  (alu_carry),
        .err    (alu_err)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        pop          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_tag_d    = op_q.tag;
                rsp_err_d    = alu_err;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            op_d = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{a: cmd_a, b: cmd_b,
                                mode: cmd_mode, tag: cmd_tag};
        end
        // pointers wrap naturally since DEPTH is a power of two
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            op_q         <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            op_q         <= op_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: directed vector table plus
// sequences for capacity, reset mid-operation and streaming.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [3:0]       cmd_mode;
    logic [3:0]       cmd_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic [3:0]       rsp_tag;
    logic             rsp_err;
    logic [CW-1:0]    fifo_count;

    alu_cmd_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_mode   (cmd_mode),
        .cmd_tag    (cmd_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = t;
    endtask

    typedef struct {
        logic [3:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        carry;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int lat;
        int acc_n;
        int sent;
        int rcv;
        int stale;
        int cmin;
        int cmax;
        bit acc;

        vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'h0, 1'b1, 1'b0};
        vecs[1]  = '{4'd1, 32'h0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2]  = '{4'd5, 32'd1, 32'd33, 4'd2, 32'd2, 1'b0, 1'b0};
        vecs[3]  = '{4'd6, 32'h8000_0000, 32'd31, 4'd4, 32'd1, 1'b0, 1'b0};
        vecs[4]  = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5,
                     32'hF000_F000, 1'b0, 1'b0};
        vecs[5]  = '{4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6,
                     32'hFFF0_FFF0, 1'b0, 1'b0};
        vecs[6]  = '{4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7,
                     32'h0FF0_0FF0, 1'b0, 1'b0};
        vecs[7]  = '{4'hA, 32'd5, 32'd7, 4'd8, 32'd0, 1'b0, 1'b1};
        vecs[8]  = '{4'd7, 32'd6, 32'd7, 4'd9, 32'd42, 1'b0, 1'b0};
        vecs[9]  = '{4'd0, 32'd5, 32'd3, 4'd10, 32'd8, 1'b0, 1'b0};
        vecs[10] = '{4'd1, 32'd5, 32'd3, 4'd11, 32'd2, 1'b0, 1'b0};
        vecs[11] = '{4'hF, 32'd1, 32'd1, 4'd15, 32'd0, 1'b0, 1'b1};
        vecs[12] = '{4'd7, 32'h1234_5678, 32'h10, 4'd12,
                     32'h2345_6780, 1'b0, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_mode  = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;

        // reset state, with a command offered during reset
        tick();
        drive(4'd0, 32'd1, 32'd1, 4'd1);
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_carry_err", {rsp_carry, rsp_err}, 0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);

        // directed vectors, one command at a time
        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].tag);
            tick();
            cmd_valid = 1'b0;
            lat = 0;
            while (!rsp_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), lat, 2);
            chk($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
            chk($sformatf("v%0d_carry", i), rsp_carry, vecs[i].carry);
            chk($sformatf("v%0d_tag", i), rsp_tag, vecs[i].tag);
            chk($sformatf("v%0d_err", i), rsp_err, vecs[i].err);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk($sformatf("v%0d_consumed", i), rsp_valid, 0);
        end

        // capacity: six back-to-back commands, response held
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(4'd0, 32'(i), 32'd0, 4'(i));
            acc = cmd_ready;
            tick();
            if (acc) acc_n++;
            if (i == 4) chk("cap_ready_after5", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        chk("cap_accepted", acc_n, 5);
        chk("cap_fifo_count", fifo_count, 4);
        chk("cap_ready_low", cmd_ready, 0);
        rsp_ready = 1'b1;
        rcv = 0;
        lat = 0;
        for (int c = 0; c < 30 && rcv < 5; c++) begin
            if (rsp_valid) begin
                chk($sformatf("cap_tag%0d", rcv), rsp_tag, rcv);
                chk($sformatf("cap_res%0d", rcv), rsp_result, rcv);
                if (rcv > 0) begin
                    chk($sformatf("cap_gap%0d", rcv), c - lat, 2);
                end
                lat = c;
                rcv++;
            end
            tick();
        end
        chk("cap_all_returned", rcv, 5);
        rsp_ready = 1'b0;
        repeat (2) tick();

        // reset while holding a response with three queued
        for (int i = 0; i < 4; i++) begin
            drive(4'd0, 32'd100 + 32'(i), 32'd0, 4'(i));
            tick();
        end
        cmd_valid = 1'b0;
        chk("rq_fifo_count", fifo_count, 3);
        chk("rq_rsp_valid", rsp_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rq_after_valid", rsp_valid, 0);
        chk("rq_after_count", fifo_count, 0);
        chk("rq_after_ready", cmd_ready, 1);
        chk("rq_after_result", rsp_result, 0);
        rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid) stale++;
            tick();
        end
        chk("rq_no_stale", stale, 0);
        rsp_ready = 1'b0;

        // streaming from a full FIFO with both sides active
        sent = 0;
        rcv = 0;
        for (int c = 0; c < 10; c++) begin
            drive(4'd0, 32'(sent), 32'd0, 4'(sent));
            if (!cmd_ready) break;
            tick();
            sent++;
        end
        chk("st_fill_sent", sent, 5);
        chk("st_fill_count", fifo_count, 4);
        rsp_ready = 1'b1;
        cmin = 99;
        cmax = 0;
        for (int c = 0; c < 40; c++) begin
            drive(4'd0, 32'(sent), 32'd0, 4'(sent));
            if (int'(fifo_count) < cmin) cmin = int'(fifo_count);
            if (int'(fifo_count) > cmax) cmax = int'(fifo_count);
            acc = cmd_ready;
            if (rsp_valid) begin
                chk("st_res", rsp_result, rcv);
                chk("st_tag", rsp_tag, rcv % 16);
                rcv++;
            end
            tick();
            if (acc) sent++;
        end
        chk("st_count_min", cmin, DEPTH - 1);
        chk("st_count_max", cmax, DEPTH);
        cmd_valid = 1'b0;
        for (int c = 0; c < 40 && rcv < sent; c++) begin
            if (rsp_valid) begin
                chk("st_drain_res", rsp_result, rcv);
                chk("st_drain_tag", rsp_tag, rcv % 16);
                rcv++;
            end
            tick();
        end
        chk("st_total", rcv, sent);
        repeat (3) tick();
        chk("st_idle", rsp_valid, 0);
        chk("st_empty", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command presented.
REQ-006 cmd_ready  output  1  command can be accepted.
REQ-007 cmd_a  input  WIDTH  operand A.
REQ-008 cmd_b  input  WIDTH  operand B.
REQ-009 cmd_mode  input  4  operation, type alu_mode.
REQ-010 cmd_tag  input  4  caller ID, returned unchanged with the response.
REQ-011 rsp_valid  output  1  response presented.
REQ-012 rsp_ready  input  1  response consumed.
REQ-013 rsp_result  output  WIDTH  ALU result.
REQ-014 rsp_carry  output  1  carry/borrow for ADD/SUB, else 0.
REQ-015 rsp_tag  output  4  tag of the originating command.
REQ-016 rsp_err  output  1  cmd_mode was not a defined alu_mode.
REQ-017 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Accept occurs on an edge with cmd_valid && cmd_ready; the command is pushed to the FIFO.
REQ-019 cmd_ready = (fifo_count < DEPTH); it is combinational from registered state only and never depends on cmd_valid.
REQ-020 The FSM has states IDLE, EXEC, and RESP.
REQ-021 IDLE: if the FIFO is non-empty, pop the head into the operand registers and go to EXEC; otherwise stay in IDLE.
REQ-022 EXEC: the ALU evaluates the operand registers; capture result, carry, tag, and err into the response registers; go to RESP.
REQ-023 RESP: rsp_valid=1; the response registers hold stable until rsp_ready is high.
REQ-024 RESP with rsp_ready && FIFO non-empty: pop and go to EXEC. RESP with rsp_ready && FIFO empty: go to IDLE.
REQ-025 Latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE drives rsp_valid high from edge N+2.
REQ-026 Peak throughput is one response per 2 cycles.
REQ-027 Push and pop on the same edge leave fifo_count unchanged. The FIFO pointers wrap modulo DEPTH.
REQ-028 A command presented while full is not accepted and the FIFO is unchanged.
REQ-029 Total acceptance capacity with rsp_ready held low is DEPTH+1: the FIFO plus the held response.
REQ-030 Responses are returned in strict acceptance order.
REQ-031 Arithmetic follows alu_mode:
  - ADD, SUB: computed at WIDTH+1 bits; carry = bit WIDTH.
  - SLL, SRL: shift amount = cmd_b[$clog2(WIDTH)-1:0].
  - MUL: low WIDTH bits of the product.
  - AND, OR, XOR: bitwise.
REQ-032 For a mode value 8..15: rsp_result=0, rsp_carry=0, rsp_err=1. rsp_err=0 for all defined modes.

Reset
REQ-033 On rst high at an edge:
  - FSM goes to IDLE; FIFO pointers and fifo_count go to 0.
  - rsp_valid=0; rsp_result, rsp_carry, rsp_tag, rsp_err go to 0.
REQ-034 While rst is high, cmd_ready=0 and no command is accepted.
REQ-035 Reset mid-operation discards all queued and in-flight commands; no response is produced for them.

Structure
REQ-036 The alu_mode typedef is a 4-bit enum in shared package alu_pkg:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, MUL=7.
REQ-037 alu_pkg also holds the constant ALU_MODE_MAX=7, used for the rsp_err check.
REQ-038 The combinational ALU is a single instantiated sub-module, alu, driven from the operand registers.
REQ-039 The FIFO is inline, not a separate module.

Verification
REQ-040 ADD, a=32'hFFFF_FFFF, b=1, tag=3 accepted at edge N → rsp_valid at N+2 with result=0, carry=1, tag=3, err=0.
REQ-041 SUB, a=0, b=1 → result=32'hFFFF_FFFF, carry=1. Then SLL, a=1, b=33 → result=2, carry=0.
REQ-042 rsp_ready=0, 6 back-to-back commands with tags 0..5:
  - Exactly 5 are accepted; cmd_ready is low after the 5th; fifo_count=4.
  - Releasing rsp_ready returns tags 0..4 in order, one per 2 cycles.
REQ-043 cmd_mode=4'hA, a=5, b=7 → result=0, carry=0, err=1. The next legal MUL, a=6, b=7, gives result=42, err=0.
REQ-044 rst asserted for 1 cycle while in RESP with 3 queued commands → next cycle: rsp_valid=0, fifo_count=0, cmd_ready=1; no stale response ever appears.
REQ-045 Full FIFO with rsp_ready=1 and cmd_valid=1 continuously → fifo_count stays at DEPTH-1..DEPTH, no loss or duplication, tags in order.
